// File: rtl/vga_pong_video_if.sv
// rtl/vga_pong_video_if.sv - position inputs from pong_game and VGA outputs of the video front-end
interface vga_pong_video_if #(
  parameter int COLOR_W = 4
);
  logic [9:0]         ball_x;
  logic [9:0]         ball_y;
  logic [9:0]         paddle_x;
  logic [9:0]         paddle_y;
  logic               frame_start;
  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;

  modport master (
    input  ball_x, ball_y, paddle_x, paddle_y,
    output frame_start, hsync, vsync, red, green, blue
  );

  modport slave (
    output ball_x, ball_y, paddle_x, paddle_y,
    input  frame_start, hsync, vsync, red, green, blue
  );
endinterface

// File: rtl/vga_pong_video.sv
// rtl/vga_pong_video.sv - 640x480@60 VGA timing, per-frame position snapshot and two-stage sprite renderer
module vga_pong_video #(
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 64,
  parameter int COLOR_W   = 4,
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic             clk,
  input  logic             reset,
  vga_pong_video_if.master vid
);

  localparam logic [9:0]  H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_VIS_L = 10'(H_VIS);
  localparam logic [9:0]  V_VIS_L = 10'(V_VIS);
  localparam logic [9:0]  H_SS    = 10'(H_VIS + H_FP);
  localparam logic [9:0]  H_SE    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  V_SS    = 10'(V_VIS + V_FP);
  localparam logic [9:0]  V_SE    = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [10:0] BALL_L  = 11'(BALL_SIZE);
  localparam logic [10:0] PW_L    = 11'(PADDLE_W);
  localparam logic [10:0] PH_L    = 11'(PADDLE_H);

  logic [9:0]         h, v, h_next, v_next;
  logic [9:0]         ball_x_q, ball_y_q, paddle_x_q, paddle_y_q;
  logic               snap_valid;
  logic               vis_s1, ball_s1, paddle_s1, hsync_s1, vsync_s1;
  logic               frame_start_q, hsync_q, vsync_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;
  logic               ball_hit, paddle_hit, visible;

  always_comb begin
    h_next = h + 10'd1;
    v_next = v;
    if (h == H_LAST) begin
      h_next = '0;
      v_next = (v == V_LAST) ? '0 : v + 10'd1;
    end
  end

  // 11-bit compare so a sprite near x=1023 clips instead of wrapping onto column 0
  function automatic logic in_span(logic [9:0] pos, logic [9:0] origin, logic [10:0] size);
    return ({1'b0, pos} >= {1'b0, origin}) && ({1'b0, pos} < ({1'b0, origin} + size));
  endfunction

  assign ball_hit   = in_span(h, ball_x_q, BALL_L) && in_span(v, ball_y_q, BALL_L);
  assign paddle_hit = in_span(h, paddle_x_q, PW_L) && in_span(v, paddle_y_q, PH_L);
  assign visible    = snap_valid && (h < H_VIS_L) && (v < V_VIS_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      h             <= '0;
      v             <= '0;
      frame_start_q <= 1'b0;
      ball_x_q      <= '0;
      ball_y_q      <= '0;
      paddle_x_q    <= '0;
      paddle_y_q    <= '0;
      snap_valid    <= 1'b0;
      vis_s1        <= 1'b0;
      ball_s1       <= 1'b0;
      paddle_s1     <= 1'b0;
      hsync_s1      <= 1'b1;
      vsync_s1      <= 1'b1;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      h             <= h_next;
      v             <= v_next;
      frame_start_q <= (h_next == '0) && (v_next == V_VIS_L);
      // Latch positions on the last cycle of the frame so the next frame never tears
      if (h == H_LAST && v == V_LAST) begin
        ball_x_q   <= vid.ball_x;
        ball_y_q   <= vid.ball_y;
        paddle_x_q <= vid.paddle_x;
        paddle_y_q <= vid.paddle_y;
        snap_valid <= 1'b1;
      end
      vis_s1    <= visible;
      ball_s1   <= ball_hit;
      paddle_s1 <= paddle_hit;
      hsync_s1  <= !((h >= H_SS) && (h < H_SE));
      vsync_s1  <= !((v >= V_SS) && (v < V_SE));
      hsync_q   <= hsync_s1;
      vsync_q   <= vsync_s1;
      red_q     <= (vis_s1 && ball_s1) ? '1 : '0;
      green_q   <= (vis_s1 && (ball_s1 || paddle_s1)) ? '1 : '0;
      blue_q    <= (vis_s1 && ball_s1) ? '1 : '0;
    end
  end

  assign vid.frame_start = frame_start_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.red         = red_q;
  assign vid.green       = green_q;
  assign vid.blue        = blue_q;

endmodule
